// File: rtl/safe_eval_seq.sv
// ---------------------------------------------------------------------------
// safe_eval_seq
// Sequential safe-cracker controller. Holds a secret code of N_POS symbols,
// accepts one guess at a time and evaluates it over N_POS+1 cycles. The
// controller reports per-position exact and misplaced flags with their
// counts, counts failed attempts, and either opens or locks out.
//
// Ports
//   clk           rising-edge clock
//   reset_n       asynchronous active-low reset
//   load_secret   pulse: capture secret, restart the game (highest priority)
//   secret        secret code, position i = bits [i*SYM_W +: SYM_W]
//   guess_valid   guess offered
//   guess         guess code, same packing as secret
//   guess_ready   high only in ARMED
//   result_valid  evaluation result available (held until result_ready)
//   result_ready  result consumed
//   c_vec         exact-match flag per position
//   m_vec         misplaced flag per guess position
//   exact_cnt     popcount(c_vec)
//   misp_cnt      popcount(m_vec)
//   tries_used    failed guesses since the controller was armed
//   unlocked      high in OPEN
//   locked_out    high in LOCK
//   dbg_state     current FSM state encoding
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. The sender holds valid (and data) until that edge; ready never
// depends on valid. The guess port is ready only in ARMED. result_valid stays
// high with stable data until the edge where result_ready is seen.
// ---------------------------------------------------------------------------
module safe_eval_seq #(
   parameter int N_POS       = 4,
   parameter int SYM_W       = 2,
   parameter int MAX_TRIES   = 8,
   parameter int LOCKOUT_CYC = 16
) (
   input  logic                             clk,
   input  logic                             reset_n,
   input  logic                             load_secret,
   input  logic [N_POS*SYM_W-1:0]           secret,
   input  logic                             guess_valid,
   input  logic [N_POS*SYM_W-1:0]           guess,
   output logic                             guess_ready,
   output logic                             result_valid,
   input  logic                             result_ready,
   output logic [N_POS-1:0]                 c_vec,
   output logic [N_POS-1:0]                 m_vec,
   output logic [$clog2(N_POS+1)-1:0]       exact_cnt,
   output logic [$clog2(N_POS+1)-1:0]       misp_cnt,
   output logic [$clog2(MAX_TRIES+1)-1:0]   tries_used,
   output logic                             unlocked,
   output logic                             locked_out,
   output logic [2:0]                       dbg_state
);

   localparam int CNT_W = $clog2(N_POS+1);
   localparam int TRY_W = $clog2(MAX_TRIES+1);
   localparam int PW    = (N_POS > 1) ? $clog2(N_POS) : 1;
   localparam int LW    = (LOCKOUT_CYC > 1) ? $clog2(LOCKOUT_CYC) : 1;

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_ARMED  = 3'd1;
   localparam logic [2:0] S_CMP    = 3'd2;
   localparam logic [2:0] S_SCAN   = 3'd3;
   localparam logic [2:0] S_RESULT = 3'd4;
   localparam logic [2:0] S_OPEN   = 3'd5;
   localparam logic [2:0] S_LOCK   = 3'd6;

   logic [2:0]             state;
   logic [N_POS*SYM_W-1:0] secret_q;
   logic [N_POS*SYM_W-1:0] guess_q;
   logic [PW-1:0]          scan_idx;
   logic [LW-1:0]          lock_cnt;

   logic [N_POS-1:0]       cmp_vec;
   logic [CNT_W-1:0]       cmp_cnt;
   logic                   scan_bit;
   logic [TRY_W-1:0]       tries_next;

   assign guess_ready  = (state == S_ARMED);
   assign result_valid = (state == S_RESULT);
   assign unlocked     = (state == S_OPEN);
   assign locked_out   = (state == S_LOCK);
   assign dbg_state    = state;
   assign tries_next   = tries_used + TRY_W'(1);

   // Exact comparison of every position and its population count.
   always_comb begin
      cmp_vec = '0;
      cmp_cnt = '0;
      for (int i = 0; i < N_POS; i++) begin
         cmp_vec[i] = (guess_q[i*SYM_W +: SYM_W] == secret_q[i*SYM_W +: SYM_W]);
         cmp_cnt    = cmp_cnt + CNT_W'(cmp_vec[i]);
      end
   end

   // Misplaced flag for guess position scan_idx. Each guess position is
   // judged independently against all non-exact secret positions, so
   // duplicated guess symbols may all be flagged against a single secret
   // symbol (no one-to-one pairing).
   always_comb begin
      scan_bit = 1'b0;
      for (int j = 0; j < N_POS; j++) begin
         if ((j != int'(scan_idx)) && !c_vec[j] &&
             (guess_q[int'(scan_idx)*SYM_W +: SYM_W] == secret_q[j*SYM_W +: SYM_W]))
            scan_bit = 1'b1;
      end
      scan_bit = scan_bit & ~c_vec[scan_idx];
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state      <= S_IDLE;
         secret_q   <= '0;
         guess_q    <= '0;
         scan_idx   <= '0;
         lock_cnt   <= '0;
         c_vec      <= '0;
         m_vec      <= '0;
         exact_cnt  <= '0;
         misp_cnt   <= '0;
         tries_used <= '0;
      end else if (load_secret) begin
         // Restart from any state; an evaluation in flight is discarded.
         state      <= S_ARMED;
         secret_q   <= secret;
         scan_idx   <= '0;
         c_vec      <= '0;
         m_vec      <= '0;
         exact_cnt  <= '0;
         misp_cnt   <= '0;
         tries_used <= '0;
      end else begin
         case (state)
            S_ARMED: begin
               if (guess_valid) begin
                  guess_q <= guess;
                  state   <= S_CMP;
               end
            end
            S_CMP: begin
               c_vec     <= cmp_vec;
               exact_cnt <= cmp_cnt;
               m_vec     <= '0;
               misp_cnt  <= '0;
               scan_idx  <= '0;
               state     <= S_SCAN;
            end
            S_SCAN: begin
               m_vec[scan_idx] <= scan_bit;
               misp_cnt        <= misp_cnt + CNT_W'(scan_bit);
               if (scan_idx == PW'(N_POS-1)) state <= S_RESULT;
               else                          scan_idx <= scan_idx + PW'(1);
            end
            S_RESULT: begin
               if (result_ready) begin
                  if (exact_cnt == CNT_W'(N_POS)) begin
                     state <= S_OPEN;
                  end else begin
                     tries_used <= tries_next;
                     if (tries_next == TRY_W'(MAX_TRIES)) begin
                        state    <= S_LOCK;
                        lock_cnt <= LW'(LOCKOUT_CYC-1);
                     end else begin
                        state <= S_ARMED;
                     end
                  end
               end
            end
            S_LOCK: begin
               if (lock_cnt == '0) begin
                  state      <= S_ARMED;
                  tries_used <= '0;
               end else begin
                  lock_cnt <= lock_cnt - LW'(1);
               end
            end
            S_IDLE, S_OPEN: ;
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_safe_eval_seq.sv
`timescale 1ns/1ps
module tb_safe_eval_seq;

   localparam int N_POS = 4;
   localparam int SYM_W = 2;
   localparam int MAX_TRIES = 3;
   localparam int LOCKOUT_CYC = 8;
   localparam int W = N_POS*SYM_W;

   // clock / reset
   logic clk = 1'b0;
   logic reset_n = 1'b0;
   always #5 clk = ~clk;

   logic          load_secret = 1'b0;
   logic [W-1:0]  secret = '0;
   logic          guess_valid = 1'b0;
   logic [W-1:0]  guess = '0;
   logic          guess_ready;
   logic          result_valid;
   logic          result_ready = 1'b0;
   logic [3:0]    c_vec, m_vec;
   logic [2:0]    exact_cnt, misp_cnt;
   logic [1:0]    tries_used;
   logic          unlocked, locked_out;
   logic [2:0]    dbg_state;

   int checks = 0;
   int errors = 0;

   safe_eval_seq #(.N_POS(N_POS), .SYM_W(SYM_W), .MAX_TRIES(MAX_TRIES), .LOCKOUT_CYC(LOCKOUT_CYC)) dut (
      .clk(clk), .reset_n(reset_n), .load_secret(load_secret), .secret(secret),
      .guess_valid(guess_valid), .guess(guess), .guess_ready(guess_ready),
      .result_valid(result_valid), .result_ready(result_ready),
      .c_vec(c_vec), .m_vec(m_vec), .exact_cnt(exact_cnt), .misp_cnt(misp_cnt),
      .tries_used(tries_used), .unlocked(unlocked), .locked_out(locked_out),
      .dbg_state(dbg_state)
   );

   // driver tasks: inputs change 1ns after the rising edge, outputs sampled there too
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      tick();
      tick();
      reset_n = 1'b1;
      tick();
   endtask

   task automatic load(input logic [W-1:0] s);
      secret = s;
      load_secret = 1'b1;
      tick();
      load_secret = 1'b0;
   endtask

   // Offers a guess, returns the number of edges from acceptance to result_valid.
   task automatic submit(input logic [W-1:0] g, output int lat);
      int n;
      guess = g;
      guess_valid = 1'b1;
      tick();
      guess_valid = 1'b0;
      n = 0;
      while (!result_valid && n < 20) begin
         tick();
         n++;
      end
      lat = n;
   endtask

   task automatic ack();
      result_ready = 1'b1;
      tick();
      result_ready = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      checks++; if (guess_ready !== 1'b0) begin errors++; $display("FAIL reset_guess_ready got %b exp 0", guess_ready); end
      checks++; if (result_valid !== 1'b0) begin errors++; $display("FAIL reset_result_valid got %b exp 0", result_valid); end
      checks++; if ({c_vec, m_vec, exact_cnt, misp_cnt, tries_used} !== '0) begin errors++; $display("FAIL reset_outputs got %h exp 0", {c_vec, m_vec, exact_cnt, misp_cnt, tries_used}); end
      checks++; if ({unlocked, locked_out} !== 2'b00) begin errors++; $display("FAIL reset_flags got %b exp 00", {unlocked, locked_out}); end
      checks++; if (dbg_state !== 3'd0) begin errors++; $display("FAIL reset_state got %0d exp 0", dbg_state); end
      // guess ignored in IDLE
      guess = 8'hE4; guess_valid = 1'b1; tick(); tick(); guess_valid = 1'b0;
      checks++; if (dbg_state !== 3'd0) begin errors++; $display("FAIL idle_ignore got %0d exp 0", dbg_state); end
   endtask

   task automatic test_exact();
      int lat;
      load(8'hE4);
      checks++; if (guess_ready !== 1'b1) begin errors++; $display("FAIL armed_ready got %b exp 1", guess_ready); end
      submit(8'hE4, lat);
      checks++; if (lat !== 5) begin errors++; $display("FAIL exact_latency got %0d exp 5", lat); end
      checks++; if (c_vec !== 4'b1111 || m_vec !== 4'b0000) begin errors++; $display("FAIL exact_vec got c=%b m=%b exp c=1111 m=0000", c_vec, m_vec); end
      checks++; if (exact_cnt !== 3'd4 || misp_cnt !== 3'd0) begin errors++; $display("FAIL exact_cnt got e=%0d m=%0d exp e=4 m=0", exact_cnt, misp_cnt); end
      checks++; if (guess_ready !== 1'b0) begin errors++; $display("FAIL result_ready_low got %b exp 0", guess_ready); end
      // result held while not acknowledged
      tick(); tick();
      checks++; if (result_valid !== 1'b1 || c_vec !== 4'b1111) begin errors++; $display("FAIL result_hold got v=%b c=%b exp v=1 c=1111", result_valid, c_vec); end
      ack();
      checks++; if (unlocked !== 1'b1 || guess_ready !== 1'b0 || result_valid !== 1'b0) begin errors++; $display("FAIL open got u=%b r=%b v=%b exp u=1 r=0 v=0", unlocked, guess_ready, result_valid); end
      checks++; if (tries_used !== 2'd0) begin errors++; $display("FAIL open_tries got %0d exp 0", tries_used); end
      // guesses ignored while open
      guess = 8'h1B; guess_valid = 1'b1; tick(); tick(); guess_valid = 1'b0;
      checks++; if (unlocked !== 1'b1 || dbg_state !== 3'd5) begin errors++; $display("FAIL open_ignore got u=%b st=%0d exp u=1 st=5", unlocked, dbg_state); end
   endtask

   task automatic test_misplaced();
      int lat;
      load(8'hE4);
      submit(8'h1B, lat);
      checks++; if (lat !== 5) begin errors++; $display("FAIL misp_latency got %0d exp 5", lat); end
      checks++; if (c_vec !== 4'b0000 || m_vec !== 4'b1111) begin errors++; $display("FAIL misp_vec got c=%b m=%b exp c=0000 m=1111", c_vec, m_vec); end
      checks++; if (exact_cnt !== 3'd0 || misp_cnt !== 3'd4) begin errors++; $display("FAIL misp_cnt got e=%0d m=%0d exp e=0 m=4", exact_cnt, misp_cnt); end
      ack();
      checks++; if (tries_used !== 2'd1 || guess_ready !== 1'b1) begin errors++; $display("FAIL misp_ack got t=%0d r=%b exp t=1 r=1", tries_used, guess_ready); end
      checks++; if (m_vec !== 4'b1111 || misp_cnt !== 3'd4) begin errors++; $display("FAIL misp_held got m=%b c=%0d exp m=1111 c=4", m_vec, misp_cnt); end
   endtask

   task automatic test_partial();
      int lat;
      submit(8'hE1, lat);
      checks++; if (c_vec !== 4'b1100 || m_vec !== 4'b0011) begin errors++; $display("FAIL partial_vec got c=%b m=%b exp c=1100 m=0011", c_vec, m_vec); end
      checks++; if (exact_cnt !== 3'd2 || misp_cnt !== 3'd2) begin errors++; $display("FAIL partial_cnt got e=%0d m=%0d exp e=2 m=2", exact_cnt, misp_cnt); end
      ack();
      checks++; if (tries_used !== 2'd2 || guess_ready !== 1'b1) begin errors++; $display("FAIL partial_ack got t=%0d r=%b exp t=2 r=1", tries_used, guess_ready); end
   endtask

   task automatic test_lockout();
      int lat;
      int cyc;
      submit(8'h1B, lat);
      ack();
      checks++; if (locked_out !== 1'b1 || guess_ready !== 1'b0 || tries_used !== 2'd3) begin errors++; $display("FAIL lock_enter got l=%b r=%b t=%0d exp l=1 r=0 t=3", locked_out, guess_ready, tries_used); end
      // keep offering a guess during lockout; it must be ignored
      guess = 8'hE4;
      guess_valid = 1'b1;
      cyc = 0;
      while (locked_out && cyc < 40) begin
         cyc++;
         tick();
      end
      guess_valid = 1'b0;
      checks++; if (cyc !== 8) begin errors++; $display("FAIL lock_cycles got %0d exp 8", cyc); end
      checks++; if (guess_ready !== 1'b1 || tries_used !== 2'd0 || dbg_state !== 3'd1) begin errors++; $display("FAIL lock_exit got r=%b t=%0d st=%0d exp r=1 t=0 st=1", guess_ready, tries_used, dbg_state); end
   endtask

   task automatic test_duplicates();
      int lat;
      load(8'h01);
      submit(8'h54, lat);
      checks++; if (c_vec !== 4'b0000 || m_vec !== 4'b1111) begin errors++; $display("FAIL dup_vec got c=%b m=%b exp c=0000 m=1111", c_vec, m_vec); end
      checks++; if (misp_cnt !== 3'd4 || exact_cnt !== 3'd0) begin errors++; $display("FAIL dup_cnt got e=%0d m=%0d exp e=0 m=4", exact_cnt, misp_cnt); end
      ack();
      checks++; if (tries_used !== 2'd1) begin errors++; $display("FAIL dup_tries got %0d exp 1", tries_used); end
   endtask

   task automatic test_reset_mid_scan();
      load(8'hE4);
      guess = 8'hE4; guess_valid = 1'b1; tick(); guess_valid = 1'b0;
      tick(); tick();
      checks++; if (dbg_state !== 3'd3 || c_vec !== 4'b1111) begin errors++; $display("FAIL scan_reached got st=%0d c=%b exp st=3 c=1111", dbg_state, c_vec); end
      reset_n = 1'b0;
      #1;
      checks++; if ({c_vec, m_vec, exact_cnt, misp_cnt, tries_used, guess_ready, result_valid} !== '0 || dbg_state !== 3'd0) begin errors++; $display("FAIL async_reset got st=%0d c=%b e=%0d exp all 0", dbg_state, c_vec, exact_cnt); end
      tick();
      reset_n = 1'b1;
      tick();
      checks++; if (dbg_state !== 3'd0 || result_valid !== 1'b0) begin errors++; $display("FAIL post_reset got st=%0d v=%b exp st=0 v=0", dbg_state, result_valid); end
   endtask

   task automatic test_load_mid_result();
      int lat;
      int n;
      load(8'hE4);
      submit(8'h1B, lat);
      ack();
      submit(8'hE1, lat);
      checks++; if (result_valid !== 1'b1 || tries_used !== 2'd1) begin errors++; $display("FAIL pre_abort got v=%b t=%0d exp v=1 t=1", result_valid, tries_used); end
      load(8'h1B);
      checks++; if (result_valid !== 1'b0 || guess_ready !== 1'b1 || tries_used !== 2'd0) begin errors++; $display("FAIL abort got v=%b r=%b t=%0d exp v=0 r=1 t=0", result_valid, guess_ready, tries_used); end
      checks++; if ({c_vec, m_vec, exact_cnt, misp_cnt} !== '0) begin errors++; $display("FAIL abort_clear got c=%b m=%b e=%0d mc=%0d exp 0", c_vec, m_vec, exact_cnt, misp_cnt); end
      // no stray result appears afterwards
      n = 0;
      for (int i = 0; i < 8; i++) begin
         tick();
         if (result_valid) n++;
      end
      checks++; if (n !== 0) begin errors++; $display("FAIL abort_no_result got %0d exp 0", n); end
      // back-to-back: new secret evaluates right away
      submit(8'h1B, lat);
      checks++; if (lat !== 5 || c_vec !== 4'b1111 || exact_cnt !== 3'd4) begin errors++; $display("FAIL back_to_back got lat=%0d c=%b e=%0d exp lat=5 c=1111 e=4", lat, c_vec, exact_cnt); end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

   initial begin
      test_reset();
      test_exact();
      test_misplaced();
      test_partial();
      test_lockout();
      test_duplicates();
      test_reset_mid_scan();
      test_load_mid_result();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
